// File: rtl/line_buf_ctrl_if.sv
// ---------------------------------------------------------------------------
// line_buf_ctrl_if
// Stream bundle for the three-row line buffer controller.
//   in_valid/in_ready/in_pix/in_sof : upstream pixel stream, one pixel per beat,
//                                     in_sof marks the first pixel of a frame
//   out_valid/out_ready             : downstream column handshake
//   out_col                         : {row n-2, row n-1, row n} pixels of one column
//   out_x/out_y                     : coordinates of the row-n pixel
//   out_eol                         : last column of the line
// Modports:
//   slave  - the line buffer controller (consumes pixels, produces columns)
//   master - the environment (produces pixels, consumes columns)
// ---------------------------------------------------------------------------
interface line_buf_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DWIDTH-1:0]     in_pix;
  logic                  in_sof;
  logic                  out_valid;
  logic                  out_ready;
  logic [3*DWIDTH-1:0]   out_col;
  logic [AWIDTH-1:0]     out_x;
  logic [AWIDTH-1:0]     out_y;
  logic                  out_eol;

  modport slave (
    input  in_valid, in_pix, in_sof, out_ready,
    output in_ready, out_valid, out_col, out_x, out_y, out_eol
  );

  modport master (
    output in_valid, in_pix, in_sof, out_ready,
    input  in_ready, out_valid, out_col, out_x, out_y, out_eol
  );
endinterface

// File: rtl/line_buf_ctrl.sv
// ---------------------------------------------------------------------------
// line_buf_ctrl
// Three-row line buffer controller. Each incoming pixel reads the two stored
// history pixels of its column from a dual-port SRAM (word = {row n-2, row n-1}),
// and one cycle later writes back {row n-1, row n} while presenting the full
// column {row n-2, row n-1, row n} on the output register.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   cfg_width       : active line width, sampled on each accepted in_sof pixel,
//                     clamped to [2, WORDS]
//   lb              : stream interface (line_buf_ctrl_if.slave)
//   sram_aa/da/bweba/weba : SRAM write port A (active-low write/bit enables)
//   sram_ab/webb/qb : SRAM read port B (active-low read, data one cycle later)
//
// Build option:
//   LB_ZERO_FILL_EN - when defined, the first two rows of a frame also produce
//                     output columns with the missing history taps forced to
//                     zero; when undefined, only rows y>=2 produce outputs.
// ---------------------------------------------------------------------------
module line_buf_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 11,
  parameter int WORDS  = 1920
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AWIDTH-1:0]   cfg_width,
  line_buf_ctrl_if.slave      lb,
  output logic [AWIDTH-1:0]   sram_aa,
  output logic [2*DWIDTH-1:0] sram_da,
  output logic [2*DWIDTH-1:0] sram_bweba,
  output logic                sram_weba,
  output logic [AWIDTH-1:0]   sram_ab,
  output logic                sram_webb,
  input  logic [2*DWIDTH-1:0] sram_qb
);

  typedef enum logic [1:0] {FILL0, FILL1, RUN} state_t;

  localparam logic [AWIDTH-1:0] MIN_W = AWIDTH'(2);
  localparam logic [AWIDTH-1:0] MAX_W = AWIDTH'(WORDS);
  localparam logic [AWIDTH-1:0] ONE   = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] Y_MAX = '1;

  state_t              state, state_nxt, pix_state;

  logic [AWIDTH-1:0]   x_cnt, y_cnt, line_w;
  logic [AWIDTH-1:0]   cfg_clamped, cur_w, cur_x, cur_y;
  logic                cur_eol;
  logic                accept;

  logic                s1_valid, s1_adv, s1_eol, s1_emit;
  logic [DWIDTH-1:0]   s1_pix;
  logic [AWIDTH-1:0]   s1_x, s1_y;
  state_t              s1_state;

  logic [DWIDTH-1:0]   qb_hi, qb_lo, tap_hi, tap_lo;

  logic                out_valid_q, out_eol_q;
  logic [3*DWIDTH-1:0] out_col_q;
  logic [AWIDTH-1:0]   out_x_q, out_y_q;

  // Handshake. in_ready depends only on pipeline occupancy and out_ready,
  // never on in_valid, so there is no combinational loop with upstream.
  assign s1_adv      = s1_valid & (~out_valid_q | lb.out_ready);
  assign lb.in_ready = rst & (~s1_valid | s1_adv);
  assign accept      = rst & lb.in_valid & lb.in_ready;

  // Coordinates of the pixel being accepted. A start-of-frame pixel always
  // lands at (0,0) and uses the freshly sampled width.
  assign cfg_clamped = (cfg_width < MIN_W) ? MIN_W :
                       ((cfg_width > MAX_W) ? MAX_W : cfg_width);
  assign cur_w   = lb.in_sof ? cfg_clamped : line_w;
  assign cur_x   = lb.in_sof ? '0 : x_cnt;
  assign cur_y   = lb.in_sof ? '0 : y_cnt;
  assign cur_eol = (cur_x == cur_w - ONE);

  assign qb_hi = sram_qb[2*DWIDTH-1:DWIDTH];
  assign qb_lo = sram_qb[DWIDTH-1:0];

  // SRAM ports. The read for column x is issued on accept; the data comes
  // back while the pixel sits in S1 and stays held until the next read, which
  // can only happen in the same cycle S1 advances and writes the column back.
  assign sram_ab    = accept ? cur_x : '0;
  assign sram_webb  = ~accept;
  assign sram_weba  = ~s1_adv;
  assign sram_bweba = s1_adv ? '0 : '1;
  assign sram_aa    = s1_adv ? s1_x : '0;
  assign sram_da    = s1_adv ? {qb_lo, s1_pix} : '0;

  assign lb.out_valid = out_valid_q;
  assign lb.out_col   = out_col_q;
  assign lb.out_x     = out_x_q;
  assign lb.out_y     = out_y_q;
  assign lb.out_eol   = out_eol_q;

  // Row-phase state register: FILL0 for row 0, FILL1 for row 1, RUN after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL0;
    else      state <= state_nxt;
  end

  // Row-phase next state. The state describes the row of the next pixel; a
  // start-of-frame pixel restarts from FILL0 regardless of where we were.
  always_comb begin
    pix_state = lb.in_sof ? FILL0 : state;
    state_nxt = state;
    if (accept) begin
      if (cur_eol) begin
        case (pix_state)
          FILL0:   state_nxt = FILL1;
          FILL1:   state_nxt = RUN;
          default: state_nxt = RUN;
        endcase
      end else begin
        state_nxt = pix_state;
      end
    end
  end

  // Row-phase outputs for the pixel in S1: whether it produces a column and
  // which history taps are meaningful.
  always_comb begin
    tap_hi = qb_hi;
    tap_lo = qb_lo;
`ifdef LB_ZERO_FILL_EN
    s1_emit = 1'b1;
    if (s1_state != RUN)   tap_hi = '0;
    if (s1_state == FILL0) tap_lo = '0;
`else
    s1_emit = (s1_state == RUN);
`endif
  end

  // Column/row counters and the per-frame width register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt  <= '0;
      y_cnt  <= '0;
      line_w <= MAX_W;
    end else if (accept) begin
      line_w <= cur_w;
      if (cur_eol) begin
        x_cnt <= '0;
        y_cnt <= (cur_y == Y_MAX) ? cur_y : cur_y + ONE;
      end else begin
        x_cnt <= cur_x + ONE;
        y_cnt <= cur_y;
      end
    end
  end

  // Stage S1: holds the accepted pixel while its SRAM read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_eol   <= 1'b0;
      s1_state <= FILL0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_pix   <= lb.in_pix;
      s1_x     <= cur_x;
      s1_y     <= cur_y;
      s1_eol   <= cur_eol;
      s1_state <= pix_state;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Output register. Loaded only when S1 advances with a column to emit, so
  // the payload stays frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_eol_q   <= 1'b0;
    end else if (s1_adv) begin
      out_valid_q <= s1_emit;
      if (s1_emit) begin
        out_col_q <= {tap_hi, tap_lo, s1_pix};
        out_x_q   <= s1_x;
        out_y_q   <= s1_y;
        out_eol_q <= s1_eol;
      end
    end else if (lb.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_buf_ctrl
// Self-checking bench for line_buf_ctrl. An SRAM model backs the DUT; a
// frame-level reference model (pixels stored by (row, column)) predicts every
// output column, which a monitor compares as beats leave the DUT.
// ---------------------------------------------------------------------------
module tb_line_buf_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 11;
  localparam int WORDS = 1920;
`ifdef LB_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  typedef struct {
    logic [3*DW-1:0] col;
    logic [AW-1:0]   x;
    logic [AW-1:0]   y;
    logic            eol;
    int              acyc;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   cfg_width;
  logic [AW-1:0]   sram_aa, sram_ab;
  logic [2*DW-1:0] sram_da, sram_bweba, sram_qb;
  logic            sram_weba, sram_webb;
  logic [2*DW-1:0] mem [WORDS];

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    beats = 0;
  bit    strict_lat = 1'b0;
  bit    rnd_ready = 1'b0;

  int    m_x, m_y, m_w;
  logic [DW-1:0] img [int];
  beat_t exp_q [$];

  bit              prev_stall = 1'b0;
  logic [3*DW-1:0] prev_col;
  logic [AW-1:0]   prev_x, prev_y;
  logic            prev_eol;

  line_buf_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) lb ();

  line_buf_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_width  (cfg_width),
    .lb         (lb.slave),
    .sram_aa    (sram_aa),
    .sram_da    (sram_da),
    .sram_bweba (sram_bweba),
    .sram_weba  (sram_weba),
    .sram_ab    (sram_ab),
    .sram_webb  (sram_webb),
    .sram_qb    (sram_qb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // SRAM model: registered read, bit-masked write, data held between reads.
  always @(posedge clk) begin
    if (!sram_webb) sram_qb <= mem[sram_ab];
    if (!sram_weba) mem[sram_aa] <= (sram_da & ~sram_bweba) | (mem[sram_aa] & sram_bweba);
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int key(input int y, input int x);
    return y * 4096 + x;
  endfunction

  function automatic logic [DW-1:0] px_at(input int y, input int x);
    if (y < 0) return '0;
    return img.exists(key(y, x)) ? img[key(y, x)] : '0;
  endfunction

  // Reference: place the pixel in the frame by plain arithmetic and predict
  // the column it must produce.
  task automatic model_accept(input logic [DW-1:0] pix, input logic sof);
    beat_t b;
    int x, y;
    if (sof) begin
      m_w = (int'(cfg_width) < 2) ? 2 : ((int'(cfg_width) > WORDS) ? WORDS : int'(cfg_width));
      m_x = 0;
      m_y = 0;
      img.delete();
    end
    x = m_x;
    y = m_y;
    img[key(y, x)] = pix;
    if (ZF || y >= 2) begin
      b.col  = {px_at(y - 2, x), px_at(y - 1, x), pix};
      b.x    = AW'(x);
      b.y    = AW'(y);
      b.eol  = (x == m_w - 1);
      b.acyc = cyc;
      exp_q.push_back(b);
    end
    if (x == m_w - 1) begin
      m_x = 0;
      if (m_y != (1 << AW) - 1) m_y++;
    end else begin
      m_x++;
    end
  endtask

  task automatic model_reset();
    m_x = 0;
    m_y = 0;
    m_w = WORDS;
    img.delete();
    exp_q.delete();
  endtask

  // Drive one pixel and hold it until accepted (bounded).
  task automatic apply_stimulus(input logic [DW-1:0] pix, input logic sof);
    int n = 0;
    lb.in_valid = 1'b1;
    lb.in_pix   = pix;
    lb.in_sof   = sof;
    @(negedge clk);
    while (!lb.in_ready && n < 100) begin
      @(posedge clk); #1;
      if (rnd_ready) lb.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    check_output("in_ready_timeout", lb.in_ready, 1);
    if (lb.in_ready) model_accept(pix, sof);
    @(posedge clk); #1;
    lb.in_valid = 1'b0;
    lb.in_sof   = 1'b0;
    if (rnd_ready) lb.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_line(input int first, input int count, input bit sof_first);
    for (int i = 0; i < count; i++)
      apply_stimulus(DW'(first + i), (i == 0) && sof_first);
  endtask

  task automatic check_reset_vals();
    check_output("rst_out_valid", lb.out_valid, 0);
    check_output("rst_out_col",   lb.out_col, 0);
    check_output("rst_out_x",     lb.out_x, 0);
    check_output("rst_out_y",     lb.out_y, 0);
    check_output("rst_out_eol",   lb.out_eol, 0);
    check_output("rst_weba",      sram_weba, 1);
    check_output("rst_bweba",     sram_bweba, 16'hffff);
    check_output("rst_webb",      sram_webb, 1);
    check_output("rst_aa",        sram_aa, 0);
    check_output("rst_ab",        sram_ab, 0);
  endtask

  // Output monitor: scoreboard compare, stall stability, SRAM port sanity.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("stall_valid", lb.out_valid, 1);
        check_output("stall_col",   lb.out_col, prev_col);
        check_output("stall_x",     lb.out_x, prev_x);
        check_output("stall_y",     lb.out_y, prev_y);
        check_output("stall_eol",   lb.out_eol, prev_eol);
      end
      if (lb.out_valid && lb.out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("extra_beat", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_output("out_col", lb.out_col, e.col);
          check_output("out_x",   lb.out_x, e.x);
          check_output("out_y",   lb.out_y, e.y);
          check_output("out_eol", lb.out_eol, e.eol);
          if (strict_lat) check_output("latency", 64'(cyc - e.acyc), 2);
          beats++;
        end
      end
      prev_stall = lb.out_valid && !lb.out_ready;
      prev_col   = lb.out_col;
      prev_x     = lb.out_x;
      prev_y     = lb.out_y;
      prev_eol   = lb.out_eol;
      if (!sram_weba) begin
        check_output("aa_range",   sram_aa < AW'(WORDS), 1);
        check_output("full_write", sram_bweba, 0);
      end
      if (!sram_webb) check_output("ab_range", sram_ab < AW'(WORDS), 1);
    end
  end

  initial begin
    int b0, n, w, lines;
    lb.in_valid  = 1'b0;
    lb.in_pix    = '0;
    lb.in_sof    = 1'b0;
    lb.out_ready = 1'b1;
    cfg_width    = AW'(4);
    model_reset();

    // Power-on reset values, then release.
    repeat (2) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("ready_after_rst", lb.in_ready, 1);
    @(posedge clk); #1;

    // Width 4, three lines of pixels 1..12, no backpressure.
    $display("[TB] basic three-line frame");
    strict_lat = 1'b1;
    b0 = beats;
    send_line(1, 12, 1'b1);
    idle(4);
    check_output("beat_count", beats - b0, ZF ? 12 : 4);
    strict_lat = 1'b0;

    // Backpressure for 5 cycles in the middle of a RUN line.
    $display("[TB] output stall");
    send_line(20, 10, 1'b1);
    lb.out_ready = 1'b0;
    lb.in_valid  = 1'b1;
    lb.in_pix    = DW'(30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("stall_in_ready", lb.in_ready, 0);
      check_output("stall_no_write", sram_weba, 1);
      @(posedge clk); #1;
    end
    lb.out_ready = 1'b1;
    send_line(30, 6, 1'b0);
    idle(4);

    // Start of frame in the middle of line 1.
    $display("[TB] mid-line sof");
    send_line(40, 6, 1'b1);
    send_line(50, 12, 1'b1);
    idle(4);

    // Width below minimum behaves as width 2.
    $display("[TB] width clamp low");
    cfg_width = AW'(1);
    send_line(60, 8, 1'b1);
    idle(4);

    // Randomized frames with random backpressure and occasional early sof.
    $display("[TB] random frames");
    rnd_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      cfg_width = AW'($urandom_range(0, 7));
      w = (int'(cfg_width) < 2) ? 2 : int'(cfg_width);
      lines = $urandom_range(3, 5);
      n = w * lines;
      for (int i = 0; i < n; i++)
        apply_stimulus(DW'($urandom), (i == 0) || ($urandom_range(0, 39) == 0));
    end
    rnd_ready = 1'b0;
    lb.out_ready = 1'b1;
    idle(6);
    check_output("random_drain", exp_q.size(), 0);

    // Reset asserted mid-stream with a pixel pending.
    $display("[TB] reset mid-stream");
    cfg_width = AW'(4);
    send_line(70, 6, 1'b1);
    lb.in_valid = 1'b1;
    lb.in_pix   = DW'(99);
    rst = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    lb.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_output("ready_after_mid_rst", lb.in_ready, 1);
    @(posedge clk); #1;
    send_line(80, 12, 1'b1);
    idle(4);

    // Maximum width, then an over-range width that must clamp to WORDS.
    $display("[TB] maximum width");
    cfg_width = AW'(WORDS);
    for (int i = 0; i < 3 * WORDS + 3; i++)
      apply_stimulus(DW'(i * 7 + 3), i == 0);
    cfg_width = AW'(2047);
    for (int i = 0; i < WORDS + 2; i++)
      apply_stimulus(DW'(i * 5 + 1), i == 0);

    // Bounded drain of anything still in flight.
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
